// File: rtl/wb_selfcheck_monitor.sv
// wb_selfcheck_monitor
// Run-to-completion checker that sits beside the 5-stage RV32IM pipeline.
// It mirrors the writeback debug stream into a shadow register file and
// watches decode for termination (ECALL, PC past PC_LIMIT, or timeout). It
// then walks NUM_CHECKS programmed {register, value} slots, one per cycle,
// and reports pass/fail, the error count and performance counters.
//
// Parameters: XLEN, NUM_CHECKS (1..16), SETTLE_CYCLES (1..255),
//             TIMEOUT_CYCLES, PC_LIMIT, TRACE_DEPTH (power of 2, >= 2)
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   instr_d, pc_d              decode-stage instruction and PC
//   wb_we, wb_addr, wb_data    writeback debug stream
//   cfg_we, cfg_idx, cfg_reg,
//   cfg_value, cfg_en          expected-value slot programming
//   done, pass, timeout        run status (sticky until rst)
//   err_count, first_fail_idx  check results
//   cycle_count, mul_count     performance counters
//   trace_valid/ready/data,
//   trace_overflow             writeback trace stream (WBMON_TRACE_EN only)
//
// Build option: define WBMON_TRACE_EN to build the writeback trace FIFO and
// its ports; without it no FIFO storage exists.
module wb_selfcheck_monitor #(
    parameter int          XLEN           = 32,
    parameter int          NUM_CHECKS     = 4,
    parameter int          SETTLE_CYCLES  = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000,
    parameter logic [31:0] PC_LIMIT       = 32'h0000_0090,
    parameter int          TRACE_DEPTH    = 16,
    localparam int         IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      pc_d,
    input  logic             wb_we,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [4:0]       cfg_reg,
    input  logic [XLEN-1:0]  cfg_value,
    input  logic             cfg_en,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [4:0]       err_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [31:0]      cycle_count,
    output logic [15:0]      mul_count
`ifdef WBMON_TRACE_EN
    ,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [XLEN+4:0]  trace_data,
    output logic             trace_overflow
`endif
);

    generate
        if (NUM_CHECKS < 1 || NUM_CHECKS > 16) begin : g_bad_num_checks
            $error("NUM_CHECKS must be in 1..16");
        end
        if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_trace_depth
            $error("TRACE_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CHECKS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);
    localparam logic [31:0]      ECALL_INSN  = 32'h0000_0073;

    state_t           state_q, state_d;
    logic [31:0]      cycle_q, cycle_d;
    logic [7:0]       settle_q, settle_d;
    logic [15:0]      mul_q, mul_d;
    logic             timeout_q, timeout_d;
    logic             done_q, done_d;
    logic [4:0]       err_q, err_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;
    logic             fail_seen_q, fail_seen_d;
    logic [IDX_W-1:0] chk_q, chk_d;

    logic [XLEN-1:0]  shadow_q   [32];
    logic [4:0]       slot_reg_q [NUM_CHECKS];
    logic [XLEN-1:0]  slot_val_q [NUM_CHECKS];
    logic             slot_en_q  [NUM_CHECKS];

    logic running;
    logic shadow_we;
    logic is_mul;
    logic chk_mis;

    assign running   = (state_q == S_RUN) || (state_q == S_SETTLE);
    // x0 is hard-wired to zero, so writebacks to it are never recorded.
    assign shadow_we = running && wb_we && (wb_addr != 5'd0);
    // MUL/MULH/MULHSU/MULHU only; funct3[2]=1 selects the divide group.
    assign is_mul    = (instr_d[6:0] == 7'b0110011) && (instr_d[31:25] == 7'b0000001)
                       && !instr_d[14];
    assign chk_mis   = slot_en_q[chk_q] && (shadow_q[slot_reg_q[chk_q]] != slot_val_q[chk_q]);

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        settle_d    = settle_q;
        mul_d       = mul_q;
        timeout_d   = timeout_q;
        done_d      = done_q;
        err_d       = err_q;
        ffi_d       = ffi_q;
        fail_seen_d = fail_seen_q;
        chk_d       = chk_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                cycle_d = cycle_q + 32'd1;
                if (is_mul && (mul_q != 16'hFFFF)) begin
                    mul_d = mul_q + 16'd1;
                end
                // Timeout outranks an ECALL arriving in the same cycle.
                if (cycle_d == TIMEOUT_CYCLES) begin
                    timeout_d = 1'b1;
                    state_d   = S_CHECK;
                end else if (instr_d == ECALL_INSN) begin
                    settle_d = SETTLE_INIT;
                    state_d  = S_SETTLE;
                end else if (pc_d > PC_LIMIT) begin
                    state_d = S_CHECK;
                end
            end
            S_SETTLE: begin
                cycle_d  = cycle_q + 32'd1;
                settle_d = settle_q - 8'd1;
                if (cycle_d == TIMEOUT_CYCLES) begin
                    timeout_d = 1'b1;
                    state_d   = S_CHECK;
                end else if (settle_d == 8'd0) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                chk_d = chk_q + IDX_ONE;
                if (chk_mis) begin
                    err_d = err_q + 5'd1;
                    if (!fail_seen_q) begin
                        ffi_d       = chk_q;
                        fail_seen_d = 1'b1;
                    end
                end
                if (chk_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cycle_q     <= '0;
            settle_q    <= '0;
            mul_q       <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            ffi_q       <= '0;
            fail_seen_q <= 1'b0;
            chk_q       <= '0;
            for (int r = 0; r < 32; r++) begin
                shadow_q[r] <= '0;
            end
            for (int s = 0; s < NUM_CHECKS; s++) begin
                slot_reg_q[s] <= '0;
                slot_val_q[s] <= '0;
                slot_en_q[s]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            settle_q    <= settle_d;
            mul_q       <= mul_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ffi_q       <= ffi_d;
            fail_seen_q <= fail_seen_d;
            chk_q       <= chk_d;
            if (shadow_we) begin
                shadow_q[wb_addr] <= wb_data;
            end
            // A slot rewritten during CHECK only matters if not yet evaluated.
            if (cfg_we && (int'(cfg_idx) < NUM_CHECKS)) begin
                slot_reg_q[cfg_idx] <= cfg_reg;
                slot_val_q[cfg_idx] <= cfg_value;
                slot_en_q[cfg_idx]  <= cfg_en;
            end
        end
    end

    assign done           = done_q;
    assign pass           = done_q && (err_q == 5'd0) && !timeout_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;
    assign cycle_count    = cycle_q;
    assign mul_count      = mul_q;

`ifdef WBMON_TRACE_EN
    localparam int             PTR_W   = $clog2(TRACE_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [XLEN+4:0] fifo_mem [TRACE_DEPTH];
    logic [PTR_W:0]  wr_ptr_q, rd_ptr_q;
    logic            ovf_q;
    logic            fifo_empty, fifo_full, pop, push_ok;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W])
                        && (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = shadow_we && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (shadow_we && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {wb_addr, wb_data};
        end
    end

    assign trace_valid    = !fifo_empty;
    assign trace_data     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign trace_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_wb_selfcheck_monitor.sv
// Testbench for wb_selfcheck_monitor: a table of check scenarios plus
// hand-written sequences for timing, timeout, PC limit, settle/check
// shadow behaviour, M-extension counting, mid-run reset and the trace FIFO.
module tb_wb_selfcheck_monitor;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] MUL   = 32'h0231_00B3;
    localparam logic [31:0] MULH  = 32'h0231_10B3;
    localparam logic [31:0] DIV   = 32'h0231_40B3;
    localparam logic [31:0] ADD   = 32'h0031_00B3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_d;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [4:0]  cfg_reg;
    logic [31:0] cfg_value;
    logic        cfg_en;
    logic        done, pass, timeout;
    logic [4:0]  err_count;
    logic [1:0]  first_fail_idx;
    logic [31:0] cycle_count;
    logic [15:0] mul_count;
`ifdef WBMON_TRACE_EN
    logic        trace_valid, trace_ready, trace_overflow;
    logic [36:0] trace_data;
`endif

    always #5 clk = ~clk;

    wb_selfcheck_monitor #(
        .XLEN(32), .NUM_CHECKS(4), .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(32'd50),
        .PC_LIMIT(32'h0000_0090), .TRACE_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_reg(cfg_reg),
        .cfg_value(cfg_value), .cfg_en(cfg_en),
        .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .cycle_count(cycle_count),
        .mul_count(mul_count)
`ifdef WBMON_TRACE_EN
        ,
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_data(trace_data), .trace_overflow(trace_overflow)
`endif
    );

    typedef struct {
        logic [31:0] v12, v13;
        logic [4:0]  r0, r1, r2;
        logic [31:0] e0, e1, e2;
        logic [2:0]  en;
        logic        exp_pass;
        logic [4:0]  exp_err;
        logic [1:0]  exp_ffi;
    } vec_t;

    vec_t tbl [6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        instr_d   = NOP;
        pc_d      = 32'd0;
        wb_we     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'd0;
        cfg_we    = 1'b0;
        cfg_idx   = 2'd0;
        cfg_reg   = 5'd0;
        cfg_value = 32'd0;
        cfg_en    = 1'b0;
`ifdef WBMON_TRACE_EN
        trace_ready = 1'b0;
`endif
    endtask

    // Leaves the DUT in its single IDLE cycle.
    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [4:0] r, input logic [31:0] v,
                       input logic en);
        cfg_we = 1'b1; cfg_idx = idx; cfg_reg = r; cfg_value = v; cfg_en = en;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] i);
        instr_d = i;
        tick();
        instr_d = NOP;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
        chk(name, 64'(done), 64'd1);
    endtask

    initial begin
        //              v12       v13          r0  r1  r2  e0        e1           e2  en      pass err ffi
        tbl[0] = '{32'd65536, 32'd5,       5'd12, 5'd13, 5'd0,  32'd65536, 32'd5,       32'd0, 3'b011, 1'b1, 5'd0, 2'd0};
        tbl[1] = '{32'd65536, 32'd5,       5'd12, 5'd13, 5'd0,  32'd65536, 32'd6,       32'd0, 3'b011, 1'b0, 5'd1, 2'd1};
        tbl[2] = '{32'd65536, 32'd5,       5'd12, 5'd13, 5'd14, 32'd65536, 32'd6,       32'd1, 3'b111, 1'b0, 5'd2, 2'd1};
        tbl[3] = '{32'd7,     32'hFFFFFFFF, 5'd12, 5'd13, 5'd0,  32'd8,     32'hFFFFFFFF, 32'd0, 3'b111, 1'b0, 5'd1, 2'd0};
        tbl[4] = '{32'd65536, 32'd5,       5'd12, 5'd13, 5'd5,  32'd0,     32'd0,       32'd9, 3'b000, 1'b1, 5'd0, 2'd0};
        tbl[5] = '{32'd65536, 32'd5,       5'd12, 5'd13, 5'd0,  32'd1,     32'd1,       32'd1, 3'b111, 1'b0, 5'd3, 2'd0};

        // Reset values
        do_reset();
        chk("rst done", 64'(done), 0);
        chk("rst pass", 64'(pass), 0);
        chk("rst timeout", 64'(timeout), 0);
        chk("rst err", 64'(err_count), 0);
        chk("rst ffi", 64'(first_fail_idx), 0);
        chk("rst cycles", 64'(cycle_count), 0);
        chk("rst mul", 64'(mul_count), 0);
`ifdef WBMON_TRACE_EN
        chk("rst trace_valid", 64'(trace_valid), 0);
        chk("rst trace_overflow", 64'(trace_overflow), 0);
`endif

        // Table: program writes x12, x13, then ECALL
        for (int v = 0; v < 6; v++) begin
            do_reset();
            cfg(2'd0, tbl[v].r0, tbl[v].e0, tbl[v].en[0]);
            cfg(2'd1, tbl[v].r1, tbl[v].e1, tbl[v].en[1]);
            cfg(2'd2, tbl[v].r2, tbl[v].e2, tbl[v].en[2]);
            cfg(2'd3, 5'd0, 32'd0, 1'b0);
            wb(5'd12, tbl[v].v12);
            wb(5'd13, tbl[v].v13);
            issue(ECALL);
            wait_done($sformatf("vec%0d done", v));
            chk($sformatf("vec%0d pass", v), 64'(pass), 64'(tbl[v].exp_pass));
            chk($sformatf("vec%0d err", v), 64'(err_count), 64'(tbl[v].exp_err));
            chk($sformatf("vec%0d ffi", v), 64'(first_fail_idx), 64'(tbl[v].exp_ffi));
            chk($sformatf("vec%0d timeout", v), 64'(timeout), 0);
        end

        // ECALL at E: CHECK from E+9, done from E+13, 12 counted cycles
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) tick();
        issue(ECALL);
        for (int i = 0; i < 11; i++) tick();
        chk("ecall done early", 64'(done), 0);
        tick();
        chk("ecall done on time", 64'(done), 1);
        chk("ecall cycles", 64'(cycle_count), 12);
        chk("ecall pass", 64'(pass), 1);
        for (int i = 0; i < 3; i++) tick();
        chk("done hold cycles", 64'(cycle_count), 12);
        chk("done hold", 64'(done), 1);

        // Timeout with PC kept low and no ECALL
        do_reset();
        wait_done("timeout done");
        chk("timeout flag", 64'(timeout), 1);
        chk("timeout cycles", 64'(cycle_count), 50);
        chk("timeout pass", 64'(pass), 0);

        // PC equal to the limit continues; PC above it goes straight to CHECK
        do_reset();
        tick();
        pc_d = 32'h0000_0090;
        tick();
        pc_d = 32'd0;
        tick();
        pc_d = 32'h0000_0094;
        tick();
        pc_d = 32'd0;
        for (int i = 0; i < 3; i++) tick();
        chk("pc done early", 64'(done), 0);
        tick();
        chk("pc done", 64'(done), 1);
        chk("pc cycles", 64'(cycle_count), 3);
        chk("pc timeout", 64'(timeout), 0);

        // x0 write ignored, SETTLE write seen, CHECK write not seen, disabled slot skipped
        do_reset();
        cfg(2'd0, 5'd0, 32'd0, 1'b1);
        cfg(2'd1, 5'd5, 32'h55, 1'b1);
        cfg(2'd2, 5'd6, 32'd0, 1'b1);
        cfg(2'd3, 5'd7, 32'h1234, 1'b0);
        wb(5'd0, 32'hDEADBEEF);
        issue(ECALL);
        for (int i = 0; i < 3; i++) tick();
        wb(5'd5, 32'h55);
        for (int i = 0; i < 4; i++) tick();
        wb(5'd6, 32'h77);
        wait_done("shadow done");
        chk("shadow pass", 64'(pass), 1);
        chk("shadow err", 64'(err_count), 0);

        // M-extension counting, frozen after ECALL
        do_reset();
        tick();
        issue(MUL);
        issue(MUL);
        issue(DIV);
        issue(MULH);
        issue(ADD);
        issue(MUL);
        issue(ECALL);
        chk("mul count", 64'(mul_count), 4);
        issue(MUL);
        chk("mul frozen settle", 64'(mul_count), 4);
        wait_done("mul done");
        chk("mul final", 64'(mul_count), 4);

        // Reset mid-run clears counters and config slots
        do_reset();
        cfg(2'd0, 5'd12, 32'd1, 1'b1);
        issue(MUL);
        chk("midrst mul before", 64'(mul_count), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst cycles", 64'(cycle_count), 0);
        chk("midrst mul", 64'(mul_count), 0);
        tick();
        wb(5'd12, 32'd5);
        issue(ECALL);
        wait_done("midrst done");
        chk("midrst pass", 64'(pass), 1);
        chk("midrst err", 64'(err_count), 0);

`ifdef WBMON_TRACE_EN
        // Trace FIFO: fill beyond depth with ready low, then drain in order
        do_reset();
        tick();
        wb(5'd1, 32'h101);
        chk("trace first word", 64'(trace_valid), 1);
        for (int i = 2; i <= 6; i++) wb(5'(i), 32'h100 + 32'(i));
        chk("trace overflow", 64'(trace_overflow), 1);
        trace_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("trace valid %0d", k), 64'(trace_valid), 1);
            chk($sformatf("trace data %0d", k), 64'(trace_data),
                64'({5'(k), 32'h100 + 32'(k)}));
            tick();
        end
        chk("trace empty", 64'(trace_valid), 0);
        chk("trace overflow sticky", 64'(trace_overflow), 1);
        trace_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
